// File: rtl/mult8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier driven by a single adder8.
// Accepts start in IDLE, runs eight add/shift iterations, then pulses done
// for one cycle with the 16-bit product held until the next accepted start.

// 8-bit ripple adder with carry out; the multiplier's only adder.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       carryout
);
    assign {carryout, sum} = 9'(a) + 9'(b);
endmodule

module mult8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    m;
    logic [W-1:0]    acc;
    logic [W-1:0]    q;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    add_b;
    logic [W-1:0]    add_sum;
    logic            add_carry;
    logic [PW-1:0]   shifted;
    logic            last_iter;

    // Partial-product adder: ACC plus M gated by the current multiplier bit.
    assign add_b = q[0] ? m : '0;

    adder8 u_adder8 (
        .a        (acc),
        .b        (add_b),
        .sum      (add_sum),
        .carryout (add_carry)
    );

    // {carry, sum, Q} shifted right by one; carry lands in ACC[7].
    assign shifted   = {add_carry, add_sum, q[W-1:1]};
    assign last_iter = (cnt == CW'(W - 1));

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, add/shift iterations and product capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    acc <= shifted[PW-1:W];
                    q   <= shifted[W-1:0];
                    cnt <= cnt + CW'(1);
                    if (last_iter) product <= shifted;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult8_seq.sv
// Self-checking bench for mult8_seq: directed boundary cases plus random
// operands checked against plain a*b arithmetic.
module tb_mult8_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic [15:0] last_prod = 16'd0;

    mult8_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

    // One complete operation: accept, 8 iterations, one done cycle, back to idle.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] exp;
        int n;
        int held_bad;
        exp = ref_mul(x, y);
        @(negedge clk);
        start = 1'b1; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~x; b = ~y;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL accept_busy a=%0d b=%0d busy=%b done=%b required busy=1 done=0", x, y, busy, done);
        end
        n = 0;
        held_bad = 0;
        while (done !== 1'b1 && n < 20) begin
            if (product !== last_prod) held_bad++;
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL done_latency a=%0d b=%0d edges=%0d required 8", x, y, n);
        end
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL product_hold_during_run a=%0d b=%0d changed_cycles=%0d required 0", x, y, held_bad);
        end
        total++;
        if (product !== exp || busy !== 1'b1) begin
            bad++;
            $display("FAIL product a=%0d b=%0d product=%0d busy=%b required product=%0d busy=1", x, y, product, busy, exp);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== exp) begin
            bad++;
            $display("FAIL after_done a=%0d b=%0d done=%b busy=%b product=%0d required 0 0 %0d", x, y, done, busy, product, exp);
        end
        last_prod = exp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (product !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state product=%0d busy=%b done=%b required 0 0 0", product, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
        end
        last_prod = 16'd0;
    endtask

    task automatic test_basic();
        run_op(8'd3, 8'd5);
    endtask

    task automatic test_boundaries();
        run_op(8'd255, 8'd255);
        run_op(8'd0, 8'd200);
        run_op(8'd128, 8'd0);
        run_op(8'd1, 8'd255);
        run_op(8'd255, 8'd1);
    endtask

    // A start pulse while busy must be dropped, not queued.
    task automatic test_start_while_busy();
        int dones;
        run_op(8'd128, 8'd2);
        @(negedge clk);
        start = 1'b1; a = 8'd7; b = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            start = 1'b1; a = 8'd1; b = 8'd1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (14) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 1 || product !== 16'd63 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_busy_start dones=%0d product=%0d busy=%b required 1 63 0", dones, product, busy);
        end
        last_prod = 16'd63;
    endtask

    // Asynchronous reset mid-run clears outputs before any further edge.
    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; a = 8'd17; b = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (product !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset product=%0d busy=%b done=%b required 0 0 0", product, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_prod = 16'd0;
        run_op(8'd17, 8'd9);
    endtask

    // start held high: one operation per 10 cycles.
    task automatic test_back_to_back();
        int done_cyc[$];
        int bad_prod;
        bad_prod = 0;
        @(negedge clk);
        start = 1'b1; a = 8'd10; b = 8'd12;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                done_cyc.push_back(i);
                if (product !== 16'd120) bad_prod++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done_cyc.size() != 3 || bad_prod != 0) begin
            bad++;
            $display("FAIL b2b_count dones=%0d bad_products=%0d required 3 0", done_cyc.size(), bad_prod);
        end else begin
            total++;
            if (done_cyc[1] - done_cyc[0] != 10 || done_cyc[2] - done_cyc[1] != 10 || done_cyc[0] != 8) begin
                bad++;
                $display("FAIL b2b_spacing first=%0d second=%0d third=%0d required 8 18 28", done_cyc[0], done_cyc[1], done_cyc[2]);
            end
        end
        repeat (12) @(posedge clk);
        #1;
        last_prod = 16'd120;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_start_while_busy();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
